// File: rtl/rd_ctrl_mc_if.sv
// Accelerator read-channel bundle for rd_ctrl_mc: per-channel request/ready,
// packed byte addresses, shared return data and a one-hot return strobe.
interface rd_ctrl_mc_if #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32,
    parameter int unsigned num_ch     = 2
) ();
    logic [num_ch-1:0]            acc_rd_valid;
    logic [num_ch-1:0]            acc_rd_ready;
    logic [num_ch*addr_width-1:0] acc_rd_addr;
    logic [data_width-1:0]        acc_rd_data;
    logic [num_ch-1:0]            acc_rd_data_valid;

    modport master (
        output acc_rd_valid, acc_rd_addr,
        input  acc_rd_ready, acc_rd_data, acc_rd_data_valid
    );

    modport slave (
        input  acc_rd_valid, acc_rd_addr,
        output acc_rd_ready, acc_rd_data, acc_rd_data_valid
    );
endinterface

// File: rtl/rd_ctrl_mc.sv
// Multi-channel cache read controller: round-robin arbitration into one
// lookup/miss FSM, in-order channel-ID FIFO for return routing, hit/miss counters.
module rd_ctrl_mc #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32,
    parameter int unsigned list_depth = 4,
    parameter int unsigned list_width = 32,
    parameter int unsigned num_ch     = 2,
    parameter int unsigned rsp_depth  = 4,
    parameter int unsigned cnt_width  = 16,
    localparam int unsigned TW = $clog2(list_depth),
    localparam int unsigned OW = $clog2(list_width * data_width / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rd_ctrl_mc_if.slave           acc_rd,
    output logic [addr_width-1:0] acc_index,
    output logic [1:0]            acc_cmd,
    output logic [TW-1:0]         acc_tag,
    output logic                  acc_req,
    input  logic                  acc_gnt,
    input  logic [2:0]            acc_status,
    input  logic [TW-1:0]         return_tag,
    input  logic [addr_width-1:0] return_index,
    output logic [2:0]            proc_status_r,
    output logic [addr_width-1:0] proc_addr_r,
    output logic [TW-1:0]         proc_tag_r,
    input  logic [2:0]            proc_status_w,
    input  logic [addr_width-1:0] proc_addr_w,
    input  logic [TW-1:0]         proc_tag_w,
    output logic                  fetch_req,
    input  logic                  fetch_gnt,
    output logic [1:0]            fetch_cmd,
    output logic [TW-1:0]         fetch_tag,
    output logic [addr_width-1:0] fetch_addr,
    input  logic                  fetch_done,
    output logic                  mem_ren,
    input  logic                  mem_rready,
    output logic [TW+OW-3:0]      mem_raddr,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    input  logic                  cnt_clr,
    output logic [cnt_width-1:0]  hit_cnt,
    output logic [cnt_width-1:0]  miss_cnt
);
    localparam int unsigned CW = (num_ch > 1) ? $clog2(num_ch) : 1;
    localparam int unsigned PW = $clog2(rsp_depth);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(rsp_depth);
    localparam logic [addr_width-1:0] LINE_MASK = {{(addr_width-OW){1'b1}}, {OW{1'b0}}};

    localparam logic [3:0] S_IDLE             = 4'd0;
    localparam logic [3:0] S_NORM             = 4'd1;
    localparam logic [3:0] S_WAIT_LOOKUP      = 4'd2;
    localparam logic [3:0] S_WAIT_MEM         = 4'd3;
    localparam logic [3:0] S_CHECK_CONFLICT   = 4'd4;
    localparam logic [3:0] S_ALLOCATE_LINE    = 4'd5;
    localparam logic [3:0] S_WR_REQ           = 4'd6;
    localparam logic [3:0] S_WAIT_WR_DONE     = 4'd7;
    localparam logic [3:0] S_RD_REQ           = 4'd8;
    localparam logic [3:0] S_WAIT_RD_DONE     = 4'd9;
    localparam logic [3:0] S_ACC_MEM          = 4'd10;
    localparam logic [3:0] S_UPDATE_LIST      = 4'd11;
    localparam logic [3:0] S_UPDATE_LIST_DONE = 4'd12;
    localparam logic [3:0] S_WAIT_CONFLICT    = 4'd13;

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_LOOKUP = 2'b01;
    localparam logic [1:0] CMD_ALLOC  = 2'b10;
    localparam logic [1:0] CMD_UPDATE = 2'b11;
    localparam logic [1:0] FC_WB      = 2'b00;
    localparam logic [1:0] FC_FILL    = 2'b01;

    logic [3:0]            st_q, st_d;
    logic [CW-1:0]         rr_q, ch_q, win_ch, cur_ch, kc;
    logic [addr_width-1:0] addr_q, vic_q, vic_d, win_addr, cur_addr, line_addr;
    logic [TW-1:0]         tag_q, tag_d, mtag;
    logic [1:0]            fcmd_q, fcmd_d;
    logic                  rdp_q, rdp_d;
    logic                  any_vld, arb_en, hsk, look_req, look_gnt, st_hit, mem_rhsk;
    logic                  push, pop, fifo_full;
    logic [CW-1:0]         fifo_q [rsp_depth];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           cnt_q;

    // First valid channel at or after the round-robin pointer, wrapping
    always_comb begin
        win_ch  = '0;
        any_vld = 1'b0;
        kc      = '0;
        for (int unsigned i = 0; i < num_ch; i++) begin
            kc = CW'((32'(rr_q) + i) % num_ch);
            if (!any_vld && acc_rd.acc_rd_valid[kc]) begin
                any_vld = 1'b1;
                win_ch  = kc;
            end
        end
    end

    assign fifo_full = (cnt_q == FULL_CNT);
    assign arb_en    = ((st_q == S_IDLE) || (st_q == S_NORM)) && !fifo_full;
    assign hsk       = arb_en && any_vld;
    assign win_addr  = acc_rd.acc_rd_addr[win_ch*addr_width +: addr_width];
    assign cur_addr  = hsk ? win_addr : addr_q;
    assign cur_ch    = hsk ? win_ch : ch_q;
    assign line_addr = addr_q & LINE_MASK;

    always_comb begin
        acc_rd.acc_rd_ready         = '0;
        acc_rd.acc_rd_ready[win_ch] = hsk;
    end

    assign look_req = hsk || (st_q == S_WAIT_LOOKUP);
    assign look_gnt = look_req && acc_gnt;
    assign st_hit   = (acc_status == 3'b001) || (acc_status == 3'b010) || (acc_status == 3'b110);

    always_comb begin
        st_d          = st_q;
        tag_d         = tag_q;
        vic_d         = vic_q;
        fcmd_d        = fcmd_q;
        rdp_d         = rdp_q;
        acc_req       = 1'b0;
        acc_cmd       = CMD_NONE;
        mem_ren       = 1'b0;
        mtag          = tag_q;
        proc_status_r = 3'b000;
        fetch_req     = 1'b0;
        case (st_q)
            S_NORM:        if (!hsk) st_d = S_IDLE;
            S_WAIT_MEM: begin
                mem_ren = 1'b1;
                if (mem_rready) st_d = S_NORM;
            end
            S_CHECK_CONFLICT: begin
                proc_status_r = 3'b001;
                if (((proc_status_w == 3'b001) || (proc_status_w == 3'b010)) &&
                    (proc_addr_w == line_addr))
                    st_d = S_WAIT_CONFLICT;
                else
                    st_d = S_ALLOCATE_LINE;
            end
            S_ALLOCATE_LINE: begin
                proc_status_r = 3'b010;
                acc_req       = 1'b1;
                acc_cmd       = CMD_ALLOC;
                if (acc_gnt) begin
                    tag_d = return_tag;
                    vic_d = return_index;
                    if (acc_status == 3'b010) begin
                        fcmd_d = FC_WB;
                        rdp_d  = 1'b1;
                        st_d   = S_WR_REQ;
                    end else begin
                        fcmd_d = FC_FILL;
                        st_d   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                proc_status_r = 3'b010;
                fetch_req     = 1'b1;
                if (fetch_gnt) st_d = S_WAIT_WR_DONE;
            end
            S_WAIT_WR_DONE: begin
                proc_status_r = 3'b010;
                if (fetch_done) st_d = S_UPDATE_LIST;
            end
            S_RD_REQ: begin
                proc_status_r = 3'b010;
                fetch_req     = 1'b1;
                if (fetch_gnt) st_d = S_WAIT_RD_DONE;
            end
            S_WAIT_RD_DONE: begin
                proc_status_r = 3'b010;
                if (fetch_done) begin
                    rdp_d = 1'b0;
                    st_d  = S_ACC_MEM;
                end
            end
            S_ACC_MEM: begin
                mem_ren       = 1'b1;
                proc_status_r = mem_rready ? 3'b011 : 3'b010;
                if (mem_rready) st_d = S_UPDATE_LIST;
            end
            S_UPDATE_LIST: begin
                proc_status_r = 3'b010;
                acc_req       = 1'b1;
                acc_cmd       = CMD_UPDATE;
                if (acc_gnt) begin
                    if (rdp_q) begin
                        fcmd_d = FC_FILL;
                        st_d   = S_RD_REQ;
                    end else begin
                        st_d = S_UPDATE_LIST_DONE;
                    end
                end
            end
            S_UPDATE_LIST_DONE: if (proc_status_w != 3'b100) st_d = S_NORM;
            S_WAIT_CONFLICT: begin
                proc_status_r = 3'b100;
                if ((proc_status_w != 3'b001) && (proc_status_w != 3'b010)) begin
                    tag_d = proc_tag_w;
                    st_d  = S_ACC_MEM;
                end
            end
            S_IDLE, S_WAIT_LOOKUP: ;
            default: st_d = S_IDLE;
        endcase
        // Lookup is shared by the arbitration cycle and WAIT_LOOKUP, so it overrides the case above
        if (look_req) begin
            acc_req = 1'b1;
            acc_cmd = CMD_LOOKUP;
            if (!acc_gnt) begin
                st_d = S_WAIT_LOOKUP;
            end else if (st_hit) begin
                mem_ren = 1'b1;
                mtag    = return_tag;
                tag_d   = return_tag;
                st_d    = mem_rready ? S_NORM : S_WAIT_MEM;
            end else if (acc_status == 3'b000) begin
                st_d = S_CHECK_CONFLICT;
            end else begin
                st_d = S_WAIT_CONFLICT;
            end
        end
    end

    assign mem_rhsk    = mem_ren && mem_rready;
    assign mem_raddr   = {mtag, cur_addr[OW-1:2]};
    assign acc_index   = cur_addr & LINE_MASK;
    assign acc_tag     = tag_q;
    assign proc_addr_r = line_addr;
    assign proc_tag_r  = tag_q;
    assign fetch_cmd   = fcmd_q;
    assign fetch_tag   = tag_q;
    assign fetch_addr  = (st_q == S_WR_REQ) ? vic_q : line_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            rr_q   <= '0;
            addr_q <= '0;
            ch_q   <= '0;
            tag_q  <= '0;
            vic_q  <= '0;
            fcmd_q <= FC_WB;
            rdp_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            tag_q  <= tag_d;
            vic_q  <= vic_d;
            fcmd_q <= fcmd_d;
            rdp_q  <= rdp_d;
            if (hsk) begin
                addr_q <= win_addr;
                ch_q   <= win_ch;
                rr_q   <= (win_ch == CW'(num_ch - 1)) ? '0 : win_ch + 1'b1;
            end
        end
    end

    // Response routing: one entry per accepted RAM read, popped by returning data
    assign push = mem_rhsk;
    assign pop  = mem_rdata_valid && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= cur_ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign acc_rd.acc_rd_data = mem_rdata;

    always_comb begin
        acc_rd.acc_rd_data_valid                 = '0;
        acc_rd.acc_rd_data_valid[fifo_q[rd_ptr]] = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (look_gnt) begin
            if (st_hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 1'b1;
            else if ((acc_status == 3'b000) && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rd_ctrl_mc.sv
// Directed bench for rd_ctrl_mc: arbitration, hit/miss/writeback/conflict paths,
// response FIFO routing and backpressure, counter saturation and clear, reset.
module tb_rd_ctrl_mc;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TW  = 2;
    localparam int RAW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   acc_index, return_index, proc_addr_r, proc_addr_w, fetch_addr;
    logic [1:0]      acc_cmd, fetch_cmd;
    logic [TW-1:0]   acc_tag, return_tag, proc_tag_r, proc_tag_w, fetch_tag;
    logic            acc_req, acc_gnt, fetch_req, fetch_gnt, fetch_done;
    logic [2:0]      acc_status, proc_status_r, proc_status_w;
    logic            mem_ren, mem_rready, mem_rdata_valid, cnt_clr;
    logic [RAW-1:0]  mem_raddr;
    logic [DW-1:0]   mem_rdata;
    logic [15:0]     hit_cnt, miss_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    rd_ctrl_mc_if #(.addr_width(AW), .data_width(DW), .num_ch(2)) acc_rd ();

    rd_ctrl_mc #(
        .addr_width(AW), .data_width(DW), .list_depth(4), .list_width(16),
        .num_ch(2), .rsp_depth(4), .cnt_width(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .acc_rd(acc_rd),
        .acc_index(acc_index), .acc_cmd(acc_cmd), .acc_tag(acc_tag),
        .acc_req(acc_req), .acc_gnt(acc_gnt), .acc_status(acc_status),
        .return_tag(return_tag), .return_index(return_index),
        .proc_status_r(proc_status_r), .proc_addr_r(proc_addr_r), .proc_tag_r(proc_tag_r),
        .proc_status_w(proc_status_w), .proc_addr_w(proc_addr_w), .proc_tag_w(proc_tag_w),
        .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd),
        .fetch_tag(fetch_tag), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
        .mem_ren(mem_ren), .mem_rready(mem_rready), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        acc_rd.acc_rd_valid = '0;
        acc_rd.acc_rd_addr  = '0;
        acc_gnt = 0; acc_status = 0; return_tag = 0; return_index = 0;
        proc_status_w = 0; proc_addr_w = 0; proc_tag_w = 0;
        fetch_gnt = 0; fetch_done = 0;
        mem_rready = 0; mem_rdata = 0; mem_rdata_valid = 0; cnt_clr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_in();
        rst_n = 0;
        tick(); tick();
        check("rst_ready", acc_rd.acc_rd_ready, 0);
        check("rst_req", acc_req, 0);
        check("rst_fetch_cmd", fetch_cmd, 0);
        check("rst_pstat", proc_status_r, 0);
        check("rst_index", acc_index, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        rst_n = 1;
        tick();

        // Two channels, same-cycle hit grant: ch0 then ch1
        acc_rd.acc_rd_valid = 2'b11;
        acc_rd.acc_rd_addr  = {32'h80, 32'h40};
        acc_gnt = 1; acc_status = 3'b001; return_tag = 1; mem_rready = 1;
        #1;
        check("t1_rdy0", acc_rd.acc_rd_ready, 2'b01);
        check("t1_cmd", acc_cmd, 2'b01);
        check("t1_index0", acc_index, 32'h40);
        check("t1_raddr0", mem_raddr, 6'h10);
        check("t1_ren", mem_ren, 1);
        tick();
        return_tag = 3;
        #1;
        check("t1_rdy1", acc_rd.acc_rd_ready, 2'b10);
        check("t1_index1", acc_index, 32'h80);
        check("t1_raddr1", mem_raddr, 6'h30);
        tick();
        idle_in();
        mem_rdata = 32'hA5A5_0001; mem_rdata_valid = 1;
        #1;
        check("t1_dv0", acc_rd.acc_rd_data_valid, 2'b01);
        check("t1_data", acc_rd.acc_rd_data, 32'hA5A5_0001);
        tick();
        check("t1_dv1", acc_rd.acc_rd_data_valid, 2'b10);
        tick();
        mem_rdata_valid = 0;
        #1;
        check("t1_hits", hit_cnt, 2);

        // Miss, allocate with fill
        acc_rd.acc_rd_valid = 2'b01;
        acc_rd.acc_rd_addr  = {32'h0, 32'h40};
        acc_gnt = 1; acc_status = 3'b000;
        #1;
        check("t2_rdy", acc_rd.acc_rd_ready, 2'b01);
        check("t2_no_ren", mem_ren, 0);
        tick();
        idle_in();
        #1;
        check("t2_chk_pstat", proc_status_r, 3'b001);
        check("t2_paddr", proc_addr_r, 32'h40);
        check("t2_miss", miss_cnt, 1);
        tick();
        check("t2_alloc_cmd", acc_cmd, 2'b10);
        check("t2_alloc_pstat", proc_status_r, 3'b010);
        acc_gnt = 1; acc_status = 3'b001; return_tag = 2; return_index = 32'h300;
        tick();
        idle_in();
        #1;
        check("t2_freq", fetch_req, 1);
        check("t2_fcmd", fetch_cmd, 2'b01);
        check("t2_faddr", fetch_addr, 32'h40);
        check("t2_ftag", fetch_tag, 2);
        fetch_gnt = 1; tick(); fetch_gnt = 0;
        fetch_done = 1; tick(); fetch_done = 0;
        #1;
        check("t2_accmem_ren", mem_ren, 1);
        check("t2_accmem_raddr", mem_raddr, 6'h20);
        check("t2_accmem_pstat", proc_status_r, 3'b010);
        mem_rready = 1;
        #1;
        check("t2_accmem_hsk_pstat", proc_status_r, 3'b011);
        tick();
        mem_rready = 0;
        #1;
        check("t2_upd_cmd", acc_cmd, 2'b11);
        check("t2_upd_tag", acc_tag, 2);
        check("t2_ptag", proc_tag_r, 2);
        acc_gnt = 1; tick(); acc_gnt = 0;
        proc_status_w = 3'b100; acc_rd.acc_rd_valid = 2'b01;
        #1;
        check("t2_done_blocks", acc_rd.acc_rd_ready, 2'b00);
        tick();
        proc_status_w = 0; acc_rd.acc_rd_valid = 0;
        tick();
        mem_rdata_valid = 1;
        #1;
        check("t2_dv", acc_rd.acc_rd_data_valid, 2'b01);
        tick();
        mem_rdata_valid = 0;

        // Miss with dirty victim: writeback, update, then fill
        acc_rd.acc_rd_valid = 2'b10;
        acc_rd.acc_rd_addr  = {32'h40, 32'h0};
        acc_gnt = 1; acc_status = 3'b000;
        #1;
        check("t3_rdy", acc_rd.acc_rd_ready, 2'b10);
        tick();
        idle_in();
        tick();
        acc_gnt = 1; acc_status = 3'b010; return_tag = 3; return_index = 32'h200;
        tick();
        idle_in();
        #1;
        check("t3_wr_freq", fetch_req, 1);
        check("t3_wr_fcmd", fetch_cmd, 2'b00);
        check("t3_wr_faddr", fetch_addr, 32'h200);
        check("t3_wr_ftag", fetch_tag, 3);
        fetch_gnt = 1; tick(); fetch_gnt = 0;
        fetch_done = 1; tick(); fetch_done = 0;
        #1;
        check("t3_upd_cmd", acc_cmd, 2'b11);
        check("t3_upd_tag", acc_tag, 3);
        acc_gnt = 1; tick(); acc_gnt = 0;
        #1;
        check("t3_rd_freq", fetch_req, 1);
        check("t3_rd_fcmd", fetch_cmd, 2'b01);
        check("t3_rd_faddr", fetch_addr, 32'h40);
        fetch_gnt = 1; tick(); fetch_gnt = 0;
        fetch_done = 1; tick(); fetch_done = 0;
        #1;
        check("t3_accmem_ren", mem_ren, 1);
        check("t3_accmem_raddr", mem_raddr, 6'h30);
        mem_rready = 1; tick(); mem_rready = 0;
        acc_gnt = 1; tick(); acc_gnt = 0;
        #1;
        check("t3_done_req", acc_req, 0);
        check("t3_done_freq", fetch_req, 0);
        tick();
        mem_rdata_valid = 1;
        #1;
        check("t3_dv", acc_rd.acc_rd_data_valid, 2'b10);
        check("t3_miss", miss_cnt, 2);
        tick();
        mem_rdata_valid = 0;

        // Miss colliding with a write controller fill of the same line
        acc_rd.acc_rd_valid = 2'b01;
        acc_rd.acc_rd_addr  = {32'h0, 32'h40};
        acc_gnt = 1; acc_status = 3'b000;
        proc_status_w = 3'b010; proc_addr_w = 32'h40;
        tick();
        acc_rd.acc_rd_valid = 0; acc_gnt = 0;
        tick();
        check("t4_wait_pstat", proc_status_r, 3'b100);
        tick();
        check("t4_wait_noren", mem_ren, 0);
        proc_status_w = 3'b011; proc_tag_w = 2;
        tick();
        check("t4_accmem_ren", mem_ren, 1);
        check("t4_accmem_tag", mem_raddr[5:4], 2);
        mem_rready = 1; tick(); mem_rready = 0;
        acc_gnt = 1; tick(); acc_gnt = 0;
        proc_status_w = 0;
        tick();
        mem_rdata_valid = 1;
        #1;
        check("t4_dv", acc_rd.acc_rd_data_valid, 2'b01);
        tick();

        // Four hits with data withheld fill the response FIFO
        idle_in();
        acc_rd.acc_rd_valid = 2'b11;
        acc_rd.acc_rd_addr  = {32'h48, 32'h44};
        acc_gnt = 1; acc_status = 3'b110; return_tag = 1; mem_rready = 1;
        #1;
        check("t5_rdy_first", acc_rd.acc_rd_ready, 2'b10);
        check("t5_raddr_off", mem_raddr, 6'h12);
        tick(); tick(); tick(); tick();
        check("t5_full", acc_rd.acc_rd_ready, 2'b00);
        mem_rdata_valid = 1;
        #1;
        check("t5_dv_head", acc_rd.acc_rd_data_valid, 2'b10);
        check("t5_full_strobe", acc_rd.acc_rd_ready, 2'b00);
        tick();
        mem_rdata_valid = 0;
        #1;
        check("t5_rdy_after", acc_rd.acc_rd_ready, 2'b10);
        tick();
        acc_rd.acc_rd_valid = 0; acc_gnt = 0; mem_rready = 0; mem_rdata_valid = 1;
        #1;
        check("t5_drain0", acc_rd.acc_rd_data_valid, 2'b01);
        tick();
        check("t5_drain1", acc_rd.acc_rd_data_valid, 2'b10);
        tick();
        check("t5_drain2", acc_rd.acc_rd_data_valid, 2'b01);
        tick();
        check("t5_drain3", acc_rd.acc_rd_data_valid, 2'b10);
        tick();
        check("t5_empty_valid", acc_rd.acc_rd_data_valid, 2'b00);
        tick();
        mem_rdata_valid = 0;

        // Counter clear and saturation
        idle_in();
        cnt_clr = 1; tick(); cnt_clr = 0;
        check("t6_clr_hit", hit_cnt, 0);
        check("t6_clr_miss", miss_cnt, 0);
        acc_rd.acc_rd_valid = 2'b01;
        acc_rd.acc_rd_addr  = {32'h0, 32'h40};
        acc_gnt = 1; acc_status = 3'b001; mem_rready = 1; mem_rdata_valid = 1;
        for (int i = 0; i < 65535; i++) tick();
        check("t6_hit_max", hit_cnt, 16'hFFFF);
        tick();
        check("t6_hit_sat", hit_cnt, 16'hFFFF);
        cnt_clr = 1; tick(); cnt_clr = 0;
        check("t6_clr_wins", hit_cnt, 0);

        // Reset in the middle of a held lookup with one response outstanding
        acc_gnt = 0; mem_rdata_valid = 0;
        tick();
        acc_rd.acc_rd_valid = 0;
        #1;
        check("t7_hold_req", acc_req, 1);
        mem_rdata_valid = 1;
        #1;
        check("t7_pending_dv", acc_rd.acc_rd_data_valid, 2'b01);
        rst_n = 0;
        #1;
        check("t7_rst_req", acc_req, 0);
        check("t7_rst_dv", acc_rd.acc_rd_data_valid, 2'b00);
        tick();
        rst_n = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rd_ctrl_mc.md
Name: rd_ctrl_mc

Overview:
- Multi-channel successor to the single-port cache read controller; sits between num_ch accelerator read channels and the shared tag list, line fetch engine and data RAM.
- Round-robin arbitrates the channels into one lookup/miss FSM.
- Routes returning read data back to the issuing channel through an in-order channel-ID FIFO.
- Adds saturating hit/miss counters.

Parameters:
addr_width, 32, address width
data_width, 32, word width (multiple of 8)
list_depth, 4, cache lines; tag width TW = $clog2(list_depth)
list_width, 32, words per line; offset width OW = $clog2(list_width*data_width/8)
num_ch, 2, accelerator read channels (>=1)
rsp_depth, 4, response-ID FIFO depth (power of 2)
cnt_width, 16, perf counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
acc_rd_valid  in  num_ch  per-channel request valid
acc_rd_ready  out  num_ch  per-channel ready (one-hot or zero)
acc_rd_addr  in  num_ch*addr_width  byte addresses; channel i at [i*addr_width +: addr_width]
acc_rd_data  out  data_width  return data (= mem_rdata)
acc_rd_data_valid  out  num_ch  one-hot return strobe
acc_index  out  addr_width  line-aligned lookup address
acc_cmd  out  2  01 lookup, 10 allocate, 11 update
acc_tag  out  TW  tag for update
acc_req  out  1  list request
acc_gnt  in  1  list grant
acc_status  in  3  list response
return_tag  in  TW  tag from list
return_index  in  addr_width  victim line address
proc_status_r  out  3  own status to write controller
proc_addr_r  out  addr_width  own line address
proc_tag_r  out  TW  own tag
proc_status_w  in  3  write controller status
proc_addr_w  in  addr_width  write controller line address
proc_tag_w  in  TW  write controller tag
fetch_req  out  1  fetch request
fetch_gnt  in  1  fetch grant
fetch_cmd  out  2  00 writeback victim, 01 fill line
fetch_tag  out  TW  line tag
fetch_addr  out  addr_width  line address
fetch_done  in  1  fetch complete pulse
mem_ren  out  1  RAM read request
mem_rready  in  1  RAM ready
mem_raddr  out  TW+OW-2  {tag, word offset}
mem_rdata  in  data_width  RAM data
mem_rdata_valid  in  1  RAM data valid, in request order
cnt_clr  in  1  synchronous counter clear
hit_cnt  out  cnt_width  lookups with a hit status
miss_cnt  out  cnt_width  lookups with status 000

Behaviour:
- Reset: FSM IDLE, rr pointer 0, FIFO empty, counters 0, latched addr/tag/index 0, fetch_cmd 00. All outputs 0 except proc_addr_r/acc_index, which derive from the latched address (0).
- Arbitration: only in IDLE/NORM and when the FIFO is not full.
  - Winner is the first valid channel at or after the rr pointer, wrapping.
  - acc_rd_ready is asserted one-hot for the winner only.
  - On handshake the rr pointer becomes winner+1 mod num_ch; the address and channel ID are latched.
- Lookup: on handshake the block issues acc_req with cmd 01 in the same cycle; without acc_gnt it goes to WAIT_LOOKUP and holds the request.
- acc_status on a lookup grant:
  - 001/010/110 (hit): mem_ren in the same cycle with {return_tag, addr[OW-1:2]}. On mem_rhsked go to NORM; otherwise go to WAIT_MEM and hold the read with the latched tag.
  - 000 (miss): go to CHECK_CONFLICT.
  - 100 (in flight): go to WAIT_CONFLICT.
- CHECK_CONFLICT (proc_status_r 001): if proc_status_w is 001/010 and proc_addr_w equals the line address, go to WAIT_CONFLICT; otherwise go to ALLOCATE_LINE.
- ALLOCATE_LINE (cmd 10, proc_status_r 010): on grant latch return_tag and return_index.
  - Status 010: fetch_cmd 00, set rd_pending, go to WR_REQ.
  - Otherwise: fetch_cmd 01, go to RD_REQ.
- WR_REQ/RD_REQ drive fetch_req and wait for fetch_gnt. fetch_addr = return_index in WR_REQ, line address in RD_REQ.
- WAIT_WR_DONE goes to UPDATE_LIST on fetch_done. WAIT_RD_DONE clears rd_pending and goes to ACC_MEM on fetch_done.
- ACC_MEM: mem_ren with the latched tag; proc_status_r is 011 in the handshake cycle, 010 otherwise; on handshake go to UPDATE_LIST.
- UPDATE_LIST (cmd 11, acc_tag = latched tag): on grant go to RD_REQ with fetch_cmd 01 if rd_pending, else to UPDATE_LIST_DONE.
- UPDATE_LIST_DONE waits while proc_status_w == 100, then goes to NORM.
- WAIT_CONFLICT (proc_status_r 100): when proc_status_w is neither 001 nor 010, latch proc_tag_w and go to ACC_MEM.
- NORM without a new handshake goes to IDLE.
- Response FIFO:
  - Push the latched/current channel ID on every mem_rhsked; pop on mem_rdata_valid.
  - acc_rd_data_valid = onehot(FIFO head) & mem_rdata_valid.
  - Simultaneous push and pop leaves the count unchanged.
  - mem_rdata_valid with the FIFO empty is a protocol error: no strobe, no pop.
- Counters: +1 on a lookup grant (hit_cnt for statuses 001/010/110, miss_cnt for 000); saturate at all-ones. cnt_clr wins over an increment in the same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight FIFO entries are discarded.

Test Plan:
- num_ch=2, both channels valid, addrs 0x40/0x80, lookup grant with status 001 in the same cycle -> ready to ch0 then ch1 on consecutive cycles; data strobes one-hot 01 then 10; hit_cnt=2.
- Lookup status 000, allocate status 001 -> fetch_cmd 01, fetch_addr 0x40, then ACC_MEM, then UPDATE_LIST with acc_tag=return_tag; miss_cnt=1.
- Miss with allocate status 010, return_index 0x200 -> WR_REQ fetch_addr 0x200 cmd 00, update, then RD_REQ cmd 01 addr 0x40, then ACC_MEM.
- Miss while proc_status_w=010 with matching proc_addr_w -> WAIT_CONFLICT with proc_status_r 100; on status 011 with proc_tag_w=2, mem_raddr upper bits = 2.
- mem_rdata_valid withheld for 4 hits -> FIFO full, acc_rd_ready=0 until the first strobe.
- hit_cnt at 0xFFFF plus another hit -> stays 0xFFFF; cnt_clr in the same cycle -> 0.
